// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Anode patterns, active-low: all off, and one digit on.
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  localparam logic [NUM_DIGITS-1:0] AN_D0  = 4'b1110;
  localparam logic [NUM_DIGITS-1:0] AN_D1  = 4'b1101;
  localparam logic [NUM_DIGITS-1:0] AN_D2  = 4'b1011;
  localparam logic [NUM_DIGITS-1:0] AN_D3  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Four BCD/hex nibbles; element k drives digit k.
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  // Anode pattern that lights only the given digit.
  function automatic logic [NUM_DIGITS-1:0] an_sel(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] an;
    case (idx)
      2'd0:    an = AN_D0;
      2'd1:    an = AN_D1;
      2'd2:    an = AN_D2;
      default: an = AN_D3;
    endcase
    return an;
  endfunction

  // Index of the most significant nonzero nibble; 0 when the value is all zero.
  function automatic logic [1:0] msd_idx(input digits_t v);
    logic [1:0] m;
    m = 2'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (v[i] != 4'h0) m = i[1:0];
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake and display-side signals of the scan controller.
// master = the value producer / observer, slave = the controller itself.
interface seg_scan_ctrl_if;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic        load_ack;
  logic [3:0]  dat;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output en, value, load,
    input  load_ack, dat, an, frame_tick
  );

  modport slave (
    input  en, value, load,
    output load_ack, dat, an, frame_tick
  );
endinterface

// File: rtl/seg_prescaler.sv
// seg_prescaler: slot-rate counter 0..CLK_DIV-1 with a wrap pulse.
// A synchronous clear holds it at zero while the scanner is idle or disabled.
module seg_prescaler #(
  parameter  int CLK_DIV = 50000,
  localparam int CW      = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: clear wins, then wrap on the last slot cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit common-anode seven-segment scan controller.
// Each slot opens with BLANK_CYC all-off cycles so the 2-cycle segment decoder
// settles on the new nibble before its anode turns on. New values are staged
// in a pending register and swapped into the shadow only at frame boundaries
// (or straight away while idle), so a frame never mixes two values.
// Optional build macro LEADING_ZERO_BLANK_EN: keep anodes above the most
// significant nonzero digit dark (digit 0 always lights).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int            CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  scan_state_t   state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  digits_t       shadow_q, shadow_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic          pend_q, pend_d;
  logic          ack_q;

  logic [CW-1:0] cnt;
  logic          slot_tick;
  logic          presc_clr;
  logic          frame_tick;
  logic          commit;
  logic [15:0]   commit_val;
  logic          lit;

  // The prescaler only runs inside BLANK/SHOW, so the first BLANK cycle sees 0.
  assign presc_clr = !bus.en || (state_q == IDLE);

  seg_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (presc_clr),
    .cnt_o  (cnt),
    .tick_o (slot_tick)
  );

  assign frame_tick = (state_q == SHOW) && (idx_q == 2'd3) && slot_tick;

  // A load arriving with the commit is the newest value, so it goes straight in.
  assign commit     = (frame_tick && (pend_q || bus.load)) || ((state_q == IDLE) && pend_q);
  assign commit_val = bus.load ? bus.value : pend_val_q;

`ifdef LEADING_ZERO_BLANK_EN
  assign lit = (idx_q <= msd_idx(shadow_q));
`else
  assign lit = 1'b1;
`endif

  assign bus.dat        = shadow_q[idx_q];
  assign bus.an         = ((state_q == SHOW) && lit) ? an_sel(idx_q) : AN_OFF;
  assign bus.frame_tick = frame_tick;
  assign bus.load_ack   = ack_q;

  // Scan sequencing: IDLE -> BLANK -> SHOW, advancing digit on each slot tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        if (bus.en) state_d = BLANK;
      end
      BLANK: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (cnt == BLANK_LAST) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (slot_tick) begin
          state_d = BLANK;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Pending/shadow update: latest load wins, commit clears the flag.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    shadow_d   = shadow_q;
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_d     = 1'b1;
    end
    if (commit) begin
      shadow_d = commit_val;
      pend_d   = 1'b0;
    end
  end

  // State, data and ack registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      shadow_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= commit;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] dat;
    logic       ft;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected anode pattern for digit d while it is in its lit window.
  function automatic logic [3:0] exp_an(input int d, input logic [15:0] sh);
    logic [3:0] one;
`ifdef LEADING_ZERO_BLANK_EN
    int top;
    top = 0;
    for (int i = 1; i < 4; i++) if (((sh >> (4 * i)) & 16'hF) != 16'h0) top = i;
    if (d > top) return 4'hF;
`endif
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // Queue the expected outputs of n cycles of a frame showing value sh.
  task automatic push_frame(input logic [15:0] sh, input logic ack0, input int n);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      e.an  = ((s % CLK_DIV) < BLANK_CYC) ? 4'hF : exp_an(s / CLK_DIV, sh);
      e.dat = sh[(s / CLK_DIV) * 4 +: 4];
      e.ft  = (s == FRAME - 1);
      e.ack = (s == 0) && ack0;
      exp_q.push_back(e);
    end
  endtask

  // Run n cycles of a frame, comparing every cycle and issuing loads at slots ls1/ls2.
  task automatic run_frame(input logic [15:0] sh, input logic ack0,
                           input int ls1, input logic [15:0] v1,
                           input int ls2, input logic [15:0] v2, input int n);
    exp_t e;
    push_frame(sh, ack0, n);
    for (int s = 0; s < n; s++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.dat !== e.dat || bus.frame_tick !== e.ft || bus.load_ack !== e.ack) begin
        errors++;
        $display("FAIL scan sh=%h s=%0d an=%b want %b dat=%h want %h ft=%b want %b ack=%b want %b",
                 sh, s, bus.an, e.an, bus.dat, e.dat, bus.frame_tick, e.ft, bus.load_ack, e.ack);
      end
      bus.load = 1'b0;
      if (s == ls1) begin
        bus.load  = 1'b1;
        bus.value = v1;
      end else if (s == ls2) begin
        bus.load  = 1'b1;
        bus.value = v2;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    bus.en    = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (bus.an !== 4'hF)         begin errors++; $display("FAIL reset_an got %b want 1111", bus.an); end
    if (bus.dat !== 4'h0)        begin errors++; $display("FAIL reset_dat got %h want 0", bus.dat); end
    if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft got %b want 0", bus.frame_tick); end
    if (bus.load_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack got %b want 0", bus.load_ack); end
    rst_n = 1'b1;
  endtask

  // Load while idle: ack two cycles after the load strobe, single pulse.
  task automatic test_idle_load();
    logic exp_ack [3] = '{1'b0, 1'b1, 1'b0};
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.load = 1'b0;
      checks++;
      if (bus.load_ack !== exp_ack[c] || bus.an !== 4'hF) begin
        errors++;
        $display("FAIL idle_load c=%0d ack=%b want %b an=%b want 1111", c, bus.load_ack, exp_ack[c], bus.an);
      end
    end
  endtask

  task automatic test_scan();
    bus.en = 1'b1;
    run_frame(16'h1234, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    run_frame(16'h1234, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_double_load();
    run_frame(16'h1234, 1'b0, 5, 16'hAAAA, 20, 16'h00F0, FRAME);
    run_frame(16'h00F0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_load_at_commit();
    run_frame(16'h00F0, 1'b0, FRAME - 1, 16'h5555, -1, 16'h0, FRAME);
    run_frame(16'h5555, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  // Drop en in digit-2 SHOW with a value pending; it commits while idle.
  task automatic test_en_drop();
    logic exp_ack [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_frame(16'h5555, 1'b0, 10, 16'h9999, -1, 16'h0, 2 * CLK_DIV + 5);
    bus.en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.an !== 4'hF || bus.frame_tick !== 1'b0 || bus.load_ack !== exp_ack[c]) begin
        errors++;
        $display("FAIL en_drop c=%0d an=%b want 1111 ft=%b want 0 ack=%b want %b",
                 c, bus.an, bus.frame_tick, bus.load_ack, exp_ack[c]);
      end
    end
    bus.en = 1'b1;
    run_frame(16'h9999, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  // Async reset between edges mid-SHOW drops outputs at once and loses the pending value.
  task automatic test_async_reset();
    run_frame(16'h9999, 1'b0, 3, 16'h7777, -1, 16'h0, CLK_DIV + 4);
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.an !== 4'hF)         begin errors++; $display("FAIL async_rst_an got %b want 1111", bus.an); end
    if (bus.dat !== 4'h0)        begin errors++; $display("FAIL async_rst_dat got %h want 0", bus.dat); end
    if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL async_rst_ft got %b want 0", bus.frame_tick); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(16'h0000, 1'b0, 5, 16'h0042, -1, 16'h0, FRAME);
  endtask

  task automatic test_sparse_values();
    run_frame(16'h0042, 1'b1, FRAME - 1, 16'h0000, -1, 16'h0, FRAME);
    run_frame(16'h0000, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_scan();
    test_double_load();
    test_load_at_commit();
    test_en_drop();
    test_async_reset();
    test_sparse_values();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
